// File: rtl/cci_mpf_shim_rx_credit_buffer_pkg.sv
// Shared types, constants and slack helpers for the RX credit buffer.
package cci_mpf_rx_buf_pkg;

  localparam int CCI_TX_ALMOST_FULL_THRESHOLD = 8;
  localparam int CCI_BEATS_PER_LINE = 4;

  typedef logic [15:0] t_rx_credits;

  // A read request can claim a full line of beats, so read slack scales by line size.
  function automatic t_rx_credits rd_slack(input int threshold);
    return t_rx_credits'(threshold * CCI_BEATS_PER_LINE);
  endfunction

  function automatic t_rx_credits wr_slack(input int threshold);
    return t_rx_credits'(threshold);
  endfunction

endpackage

// File: rtl/cci_mpf_shim_rx_credit_buffer_if.sv
// Request/response bundle between the AFU-side logic and the RX credit buffer.
interface cci_mpf_shim_rx_credit_buffer_if #(
  parameter int RD_BITS = 576,
  parameter int WR_BITS = 64
);
  logic               tx_rd_req;
  logic [1:0]         tx_rd_len;
  logic               tx_wr_req;
  logic               rd_alm_full;
  logic               wr_alm_full;
  logic               rx_rd_valid;
  logic [RD_BITS-1:0] rx_rd_data;
  logic               rx_wr_valid;
  logic [WR_BITS-1:0] rx_wr_data;
  logic [RD_BITS-1:0] rd_first;
  logic [WR_BITS-1:0] wr_first;
  logic               rd_not_empty;
  logic               wr_not_empty;
  logic               rd_deq;
  logic               wr_deq;
  logic               rd_overflow;
  logic               wr_overflow;
  logic               credit_err;
  logic [15:0]        stat_rd_throttle_cycles;
  logic [15:0]        stat_wr_throttle_cycles;

  modport slave (
    input  tx_rd_req, tx_rd_len, tx_wr_req, rx_rd_valid, rx_rd_data,
           rx_wr_valid, rx_wr_data, rd_deq, wr_deq,
    output rd_alm_full, wr_alm_full, rd_first, wr_first, rd_not_empty,
           wr_not_empty, rd_overflow, wr_overflow, credit_err,
           stat_rd_throttle_cycles, stat_wr_throttle_cycles
  );

  modport master (
    output tx_rd_req, tx_rd_len, tx_wr_req, rx_rd_valid, rx_rd_data,
           rx_wr_valid, rx_wr_data, rd_deq, wr_deq,
    input  rd_alm_full, wr_alm_full, rd_first, wr_first, rd_not_empty,
           wr_not_empty, rd_overflow, wr_overflow, credit_err,
           stat_rd_throttle_cycles, stat_wr_throttle_cycles
  );
endinterface

// File: rtl/cci_mpf_prim_fifo_lutram.sv
// Distributed-RAM FIFO with show-ahead head and sticky overflow on drops.
module cci_mpf_prim_fifo_lutram #(
  parameter int N_ENTRIES   = 64,
  parameter int N_DATA_BITS = 576
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enq_en_i,
  input  logic [N_DATA_BITS-1:0] enq_data_i,
  input  logic                   deq_en_i,
  output logic [N_DATA_BITS-1:0] first_o,
  output logic                   not_empty_o,
  output logic                   overflow_o
);
  localparam int AW = $clog2(N_ENTRIES);
  localparam logic [AW:0] FULL = (AW+1)'(N_ENTRIES);

  logic [N_DATA_BITS-1:0] mem_q [N_ENTRIES];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d, enq_s, deq_s;

  // Pointer and occupancy update; a full FIFO drops the beat.
  always_comb begin
    deq_s    = deq_en_i && (cnt_q != '0);
    enq_s    = enq_en_i && (cnt_q != FULL);
    ovf_d    = ovf_q || (enq_en_i && (cnt_q == FULL));
    wr_ptr_d = wr_ptr_q + AW'(enq_s);
    rd_ptr_d = rd_ptr_q + AW'(deq_s);
    cnt_d    = cnt_q + (AW+1)'(enq_s) - (AW+1)'(deq_s);
  end

  // Storage array; no reset so it maps onto LUT RAM.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      mem_q[wr_ptr_q] <= enq_data_i;
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign first_o     = mem_q[rd_ptr_q];
  assign not_empty_o = (cnt_q != '0);
  assign overflow_o  = ovf_q;
endmodule

// File: rtl/cci_mpf_shim_rx_credit_ctr.sv
// Free-credit counter for one response channel with registered almost-full and sticky error.
module cci_mpf_shim_rx_credit_ctr
  import cci_mpf_rx_buf_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int SLACK   = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] reserve_i,
  input  logic       release_i,
  output logic       alm_full_o,
  output logic       credit_err_o
);
  localparam int W = $clog2(ENTRIES) + 1;
  localparam logic [W:0] FULL    = (W+1)'(ENTRIES);
  localparam logic [W:0] SLACK_W = (W+1)'(SLACK);

  logic [W-1:0] free_q, free_d;
  logic [W:0]   avail_s, left_s;
  logic         alm_full_q, alm_full_d;
  logic         err_q, err_d;

  // Net reserve/release; an over-reservation clamps to zero and latches the error.
  always_comb begin
    avail_s    = (W+1)'(free_q) + (W+1)'(release_i);
    left_s     = avail_s - (W+1)'(reserve_i);
    free_d     = free_q;
    err_d      = err_q;
    if ((W+1)'(reserve_i) > avail_s) begin
      free_d = '0;
      err_d  = 1'b1;
    end else if (left_s > FULL) begin
      free_d = FULL[W-1:0];
    end else begin
      free_d = left_s[W-1:0];
    end
    alm_full_d = ((W+1)'(free_q) < SLACK_W);
  end

  // State registers; almost-full tracks the counter one cycle behind.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      free_q     <= FULL[W-1:0];
      alm_full_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      free_q     <= free_d;
      alm_full_q <= alm_full_d;
      err_q      <= err_d;
    end
  end

  assign alm_full_o   = alm_full_q;
  assign credit_err_o = err_q;
endmodule

// File: rtl/cci_mpf_shim_rx_credit_buffer.sv
// RX response buffer that reserves credits at request time and frees them on dequeue.
// Define CCI_MPF_RX_BUF_STATS_EN to build the throttle-cycle statistics counters.
module cci_mpf_shim_rx_credit_buffer
  import cci_mpf_rx_buf_pkg::*;
#(
  parameter int RD_ENTRIES = 64,
  parameter int WR_ENTRIES = 32,
  parameter int THRESHOLD  = CCI_TX_ALMOST_FULL_THRESHOLD,
  parameter int RD_BITS    = 576,
  parameter int WR_BITS    = 64
) (
  input  logic clk,
  input  logic reset_n,
  cci_mpf_shim_rx_credit_buffer_if.slave bus
);
  logic [2:0] rd_reserve_s, wr_reserve_s;
  logic       rd_err_s, wr_err_s;

  assign rd_reserve_s = bus.tx_rd_req ? (3'(bus.tx_rd_len) + 3'd1) : 3'd0;
  assign wr_reserve_s = bus.tx_wr_req ? 3'd1 : 3'd0;
  assign bus.credit_err = rd_err_s | wr_err_s;

  cci_mpf_shim_rx_credit_ctr #(.ENTRIES(RD_ENTRIES), .SLACK(int'(rd_slack(THRESHOLD)))) u_rd_ctr (
    .clk(clk), .reset_n(reset_n), .reserve_i(rd_reserve_s),
    .release_i(bus.rd_deq & bus.rd_not_empty),
    .alm_full_o(bus.rd_alm_full), .credit_err_o(rd_err_s)
  );

  cci_mpf_shim_rx_credit_ctr #(.ENTRIES(WR_ENTRIES), .SLACK(int'(wr_slack(THRESHOLD)))) u_wr_ctr (
    .clk(clk), .reset_n(reset_n), .reserve_i(wr_reserve_s),
    .release_i(bus.wr_deq & bus.wr_not_empty),
    .alm_full_o(bus.wr_alm_full), .credit_err_o(wr_err_s)
  );

  cci_mpf_prim_fifo_lutram #(.N_ENTRIES(RD_ENTRIES), .N_DATA_BITS(RD_BITS)) u_rd_fifo (
    .clk(clk), .reset_n(reset_n), .enq_en_i(bus.rx_rd_valid), .enq_data_i(bus.rx_rd_data),
    .deq_en_i(bus.rd_deq), .first_o(bus.rd_first), .not_empty_o(bus.rd_not_empty),
    .overflow_o(bus.rd_overflow)
  );

  cci_mpf_prim_fifo_lutram #(.N_ENTRIES(WR_ENTRIES), .N_DATA_BITS(WR_BITS)) u_wr_fifo (
    .clk(clk), .reset_n(reset_n), .enq_en_i(bus.rx_wr_valid), .enq_data_i(bus.rx_wr_data),
    .deq_en_i(bus.wr_deq), .first_o(bus.wr_first), .not_empty_o(bus.wr_not_empty),
    .overflow_o(bus.wr_overflow)
  );

`ifdef CCI_MPF_RX_BUF_STATS_EN
  logic [15:0] rd_stat_q, rd_stat_d, wr_stat_q, wr_stat_d;

  // Saturating count of throttled cycles per channel.
  always_comb begin
    rd_stat_d = rd_stat_q;
    wr_stat_d = wr_stat_q;
    if (bus.rd_alm_full && (rd_stat_q != 16'hFFFF)) begin
      rd_stat_d = rd_stat_q + 16'd1;
    end else begin
      rd_stat_d = rd_stat_q;
    end
    if (bus.wr_alm_full && (wr_stat_q != 16'hFFFF)) begin
      wr_stat_d = wr_stat_q + 16'd1;
    end else begin
      wr_stat_d = wr_stat_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_stat_q <= 16'd0;
      wr_stat_q <= 16'd0;
    end else begin
      rd_stat_q <= rd_stat_d;
      wr_stat_q <= wr_stat_d;
    end
  end

  assign bus.stat_rd_throttle_cycles = rd_stat_q;
  assign bus.stat_wr_throttle_cycles = wr_stat_q;
`else
  assign bus.stat_rd_throttle_cycles = 16'd0;
  assign bus.stat_wr_throttle_cycles = 16'd0;
`endif
endmodule

// File: tb/tb_cci_mpf_shim_rx_credit_buffer.sv
// Self-checking bench: directed vector table, corner sequences and a randomized run
// against a queue-based reference model of the credit buffer.
module tb_cci_mpf_shim_rx_credit_buffer;
  localparam int RDN = 64, WRN = 32, RD_SLACK = 32, WR_SLACK = 8;

  typedef struct {
    bit rst_n; bit rd_req; bit [1:0] len; bit wr_req;
    bit rdv; logic [575:0] rdd; bit wrv; logic [63:0] wrd; bit rdq; bit wrq;
  } stim_t;

  typedef struct {
    bit rd_req; bit [1:0] len; bit rdv; bit [31:0] tag; bit rdq;
    bit e_alm; bit e_ne; bit [31:0] e_first; int e_free;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cci_mpf_shim_rx_credit_buffer_if #(.RD_BITS(576), .WR_BITS(64)) bus();
  cci_mpf_shim_rx_credit_buffer #(.RD_ENTRIES(RDN), .WR_ENTRIES(WRN), .THRESHOLD(8),
    .RD_BITS(576), .WR_BITS(64)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int n_cmp = 0, n_bad = 0;
  int m_rd_free, m_wr_free, m_rd_stat, m_wr_stat;
  bit m_rd_alm, m_wr_alm, m_rd_ovf, m_wr_ovf, m_cerr;
  logic [575:0] m_rd_q[$];
  logic [63:0]  m_wr_q[$];
  vec_t tbl[22];

  function automatic logic [575:0] expand(input bit [31:0] t);
    return {18{t}};
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0};
    return s;
  endfunction

  task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic credit(inout int free, inout bit err, input int res, input bit rel, input int full);
    if (res > free + int'(rel)) begin
      free = 0;
      err  = 1'b1;
    end else begin
      free = (free + int'(rel) - res > full) ? full : free + int'(rel) - res;
    end
  endtask

  // Reference model: state after one clock edge with inputs s.
  task automatic model(input stim_t s);
    bit rd_rel, wr_rel, new_rd_alm, new_wr_alm;
    int rd_pre, wr_pre;
    if (!s.rst_n) begin
      m_rd_free = RDN; m_wr_free = WRN; m_rd_alm = 1'b1; m_wr_alm = 1'b1;
      m_rd_ovf = 1'b0; m_wr_ovf = 1'b0; m_cerr = 1'b0; m_rd_stat = 0; m_wr_stat = 0;
      m_rd_q.delete(); m_wr_q.delete();
    end else begin
`ifdef CCI_MPF_RX_BUF_STATS_EN
      if (m_rd_alm && m_rd_stat < 65535) m_rd_stat++;
      if (m_wr_alm && m_wr_stat < 65535) m_wr_stat++;
`endif
      new_rd_alm = (m_rd_free < RD_SLACK);
      new_wr_alm = (m_wr_free < WR_SLACK);
      rd_pre = m_rd_q.size(); wr_pre = m_wr_q.size();
      rd_rel = s.rdq && (rd_pre > 0);
      wr_rel = s.wrq && (wr_pre > 0);
      credit(m_rd_free, m_cerr, s.rd_req ? int'(s.len) + 1 : 0, rd_rel, RDN);
      credit(m_wr_free, m_cerr, s.wr_req ? 1 : 0, wr_rel, WRN);
      if (rd_rel) void'(m_rd_q.pop_front());
      if (wr_rel) void'(m_wr_q.pop_front());
      if (s.rdv) begin
        if (rd_pre == RDN) m_rd_ovf = 1'b1; else m_rd_q.push_back(s.rdd);
      end
      if (s.wrv) begin
        if (wr_pre == WRN) m_wr_ovf = 1'b1; else m_wr_q.push_back(s.wrd);
      end
      m_rd_alm = new_rd_alm; m_wr_alm = new_wr_alm;
    end
  endtask

  task automatic compare_all();
    check("rd_alm_full", 576'(bus.rd_alm_full), 576'(m_rd_alm));
    check("wr_alm_full", 576'(bus.wr_alm_full), 576'(m_wr_alm));
    check("rd_not_empty", 576'(bus.rd_not_empty), 576'(m_rd_q.size() > 0));
    check("wr_not_empty", 576'(bus.wr_not_empty), 576'(m_wr_q.size() > 0));
    if (m_rd_q.size() > 0) check("rd_first", bus.rd_first, m_rd_q[0]);
    if (m_wr_q.size() > 0) check("wr_first", 576'(bus.wr_first), 576'(m_wr_q[0]));
    check("rd_overflow", 576'(bus.rd_overflow), 576'(m_rd_ovf));
    check("wr_overflow", 576'(bus.wr_overflow), 576'(m_wr_ovf));
    check("credit_err", 576'(bus.credit_err), 576'(m_cerr));
    check("stat_rd", 576'(bus.stat_rd_throttle_cycles), 576'(m_rd_stat));
    check("stat_wr", 576'(bus.stat_wr_throttle_cycles), 576'(m_wr_stat));
    check("rd_free", 576'(dut.u_rd_ctr.free_q), 576'(m_rd_free));
    check("wr_free", 576'(dut.u_wr_ctr.free_q), 576'(m_wr_free));
  endtask

  task automatic step(input stim_t s);
    reset_n = s.rst_n;
    bus.tx_rd_req = s.rd_req; bus.tx_rd_len = s.len; bus.tx_wr_req = s.wr_req;
    bus.rx_rd_valid = s.rdv; bus.rx_rd_data = s.rdd;
    bus.rx_wr_valid = s.wrv; bus.rx_wr_data = s.wrd;
    bus.rd_deq = s.rdq; bus.wr_deq = s.wrq;
    @(posedge clk);
    model(s);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    stim_t s;
    s = idle(); s.rst_n = 1'b0;
    step(s); step(s);
  endtask

  initial begin
    stim_t s;
    int rd_out, wr_out;
    int exp_stat;

    for (int i = 0; i < 9; i++) tbl[i] = '{1'b1, 2'd3, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 60 - 4 * i};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        28};
    tbl[10] = '{1'b0, 2'd0, 1'b1, 32'hA0A0_0001, 1'b0, 1'b1, 1'b1, 32'hA0A0_0001, 28};
    tbl[11] = '{1'b0, 2'd0, 1'b1, 32'hB0B0_0002, 1'b0, 1'b1, 1'b1, 32'hA0A0_0001, 28};
    tbl[12] = '{1'b0, 2'd0, 1'b1, 32'hC0C0_0003, 1'b0, 1'b1, 1'b1, 32'hA0A0_0001, 28};
    tbl[13] = '{1'b0, 2'd0, 1'b1, 32'hD0D0_0004, 1'b0, 1'b1, 1'b1, 32'hA0A0_0001, 28};
    tbl[14] = '{1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hB0B0_0002, 29};
    tbl[15] = '{1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hC0C0_0003, 30};
    tbl[16] = '{1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hD0D0_0004, 31};
    tbl[17] = '{1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        32};
    tbl[18] = '{1'b0, 2'd0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32};
    tbl[19] = '{1'b0, 2'd0, 1'b1, 32'hE0E0_0005, 1'b0, 1'b0, 1'b1, 32'hE0E0_0005, 32};
    tbl[20] = '{1'b1, 2'd0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        32};
    tbl[21] = '{1'b0, 2'd0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32};

    // Reset values
    do_reset();
    check("rst_rd_alm", 576'(bus.rd_alm_full), 576'(1'b1));
    check("rst_wr_alm", 576'(bus.wr_alm_full), 576'(1'b1));
    check("rst_rd_free", 576'(dut.u_rd_ctr.free_q), 576'(RDN));
    check("rst_ne", 576'(bus.rd_not_empty), 576'(1'b0));

    // Directed vector table: throttle onset, in-order delivery, net reserve/release
    for (int i = 0; i < 22; i++) begin
      s = idle();
      s.rd_req = tbl[i].rd_req; s.len = tbl[i].len;
      s.rdv = tbl[i].rdv; s.rdd = expand(tbl[i].tag); s.rdq = tbl[i].rdq;
      step(s);
      check($sformatf("tbl%0d_alm", i), 576'(bus.rd_alm_full), 576'(tbl[i].e_alm));
      check($sformatf("tbl%0d_ne", i), 576'(bus.rd_not_empty), 576'(tbl[i].e_ne));
      check($sformatf("tbl%0d_free", i), 576'(dut.u_rd_ctr.free_q), 576'(tbl[i].e_free));
      if (tbl[i].e_ne) check($sformatf("tbl%0d_first", i), bus.rd_first, expand(tbl[i].e_first));
    end

    // Overflow: 65 beats with no dequeue
    do_reset();
    for (int i = 0; i < 65; i++) begin
      s = idle(); s.rdv = 1'b1; s.rdd = expand(32'h5000_0000 + 32'(i)); s.wrv = 1'b1; s.wrd = 64'(i);
      step(s);
      if (i == 63) check("ovf_before", 576'(bus.rd_overflow), 576'(1'b0));
    end
    check("rd_ovf_set", 576'(bus.rd_overflow), 576'(1'b1));
    check("wr_ovf_set", 576'(bus.wr_overflow), 576'(1'b1));
    for (int i = 0; i < 5; i++) step(idle());
    check("rd_ovf_sticky", 576'(bus.rd_overflow), 576'(1'b1));
    check("ovf_head", bus.rd_first, expand(32'h5000_0000));
    do_reset();
    check("ovf_clr", 576'(bus.rd_overflow), 576'(1'b0));

    // Over-reservation: bring free down to 2, then ask for 4
    for (int i = 0; i < 15; i++) begin
      s = idle(); s.rd_req = 1'b1; s.len = 2'd3; step(s);
    end
    s = idle(); s.rd_req = 1'b1; s.len = 2'd1; step(s);
    check("pre_err_free", 576'(dut.u_rd_ctr.free_q), 576'(2));
    check("pre_err", 576'(bus.credit_err), 576'(1'b0));
    s = idle(); s.rd_req = 1'b1; s.len = 2'd3; step(s);
    check("cerr_set", 576'(bus.credit_err), 576'(1'b1));
    check("cerr_free0", 576'(dut.u_rd_ctr.free_q), 576'(0));
    step(idle());
    check("cerr_sticky", 576'(bus.credit_err), 576'(1'b1));

    // Write throttle held for 100 cycles
    do_reset();
    for (int i = 0; i < 25; i++) begin
      s = idle(); s.wr_req = 1'b1; step(s);
    end
    check("wr_alm_late", 576'(bus.wr_alm_full), 576'(1'b0));
    step(idle());
    check("wr_alm_on", 576'(bus.wr_alm_full), 576'(1'b1));
    for (int i = 0; i < 100; i++) step(idle());
`ifdef CCI_MPF_RX_BUF_STATS_EN
    exp_stat = 100;
`else
    exp_stat = 0;
`endif
    check("stat_wr_100", 576'(bus.stat_wr_throttle_cycles), 576'(exp_stat));

    // Mid-operation reset discards queued data and reservations
    s = idle(); s.rd_req = 1'b1; s.len = 2'd3; s.rdv = 1'b1; s.rdd = expand(32'h1234); step(s);
    s = idle(); s.rst_n = 1'b0; step(s);
    check("mid_rst_ne", 576'(bus.rd_not_empty), 576'(1'b0));
    check("mid_rst_free", 576'(dut.u_wr_ctr.free_q), 576'(WRN));
    check("mid_rst_alm", 576'(bus.rd_alm_full), 576'(1'b1));
    step(idle());
    check("post_rst_alm", 576'(bus.rd_alm_full), 576'(1'b0));
    check("post_rst_wr_alm", 576'(bus.wr_alm_full), 576'(1'b0));

    // Randomized traffic; responses never exceed outstanding reservations
    rd_out = 0; wr_out = 0;
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      if ($urandom_range(799) == 0) s.rst_n = 1'b0;
      s.len = 2'($urandom_range(3));
      s.rd_req = ($urandom_range(9) < 3) && (m_rd_free >= int'(s.len) + 1);
      s.wr_req = ($urandom_range(9) < 4) && (m_wr_free >= 1);
      s.rdv = (rd_out > 0) && ($urandom_range(9) < 6);
      for (int w = 0; w < 18; w++) s.rdd[w*32 +: 32] = $urandom();
      s.wrv = (wr_out > 0) && ($urandom_range(9) < 6);
      s.wrd = {$urandom(), $urandom()};
      s.rdq = ($urandom_range(9) < 5);
      s.wrq = ($urandom_range(9) < 4);
      step(s);
      if (!s.rst_n) begin
        rd_out = 0; wr_out = 0;
      end else begin
        rd_out += (s.rd_req ? int'(s.len) + 1 : 0) - int'(s.rdv);
        wr_out += int'(s.wr_req) - int'(s.wrv);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cci_mpf_shim_rx_credit_buffer.md
CCI_MPF_SHIM_RX_CREDIT_BUFFER -- requirements
Module: cci_mpf_shim_rx_credit_buffer

Interface
REQ-001 SHALL have parameter RD_ENTRIES, default 64, read-response FIFO depth in beats.
REQ-002 SHALL have parameter WR_ENTRIES, default 32, write-ack FIFO depth in acks.
REQ-003 SHALL have parameter THRESHOLD, default CCI_TX_ALMOST_FULL_THRESHOLD (8), count of requests the AFU may still issue after almost-full.
REQ-004 SHALL have parameters RD_BITS, default 576, and WR_BITS, default 64: response payload widths.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port reset_n, input, 1; reset is synchronous and active-low.
REQ-007 SHALL have ports tx_rd_req / tx_rd_len, input, 1 / 2: read request issued this cycle, cl_len encoding (beats = len+1).
REQ-008 SHALL have port tx_wr_req, input, 1: write request issued this cycle; each write request consumes one ack credit.
REQ-009 SHALL have ports rd_alm_full / wr_alm_full, output, 1 each: request throttles toward the AFU.
REQ-010 SHALL have ports rx_rd_valid / rx_rd_data, input, 1 / RD_BITS, and rx_wr_valid / rx_wr_data, input, 1 / WR_BITS: unthrottled FIU responses.
REQ-011 SHALL have ports rd_first / wr_first, output, RD_BITS / WR_BITS; rd_not_empty / wr_not_empty, output, 1; rd_deq / wr_deq, input, 1.
REQ-012 SHALL have ports rd_overflow, wr_overflow and credit_err, output, 1 each: sticky error flags.
REQ-013 SHALL have ports stat_rd_throttle_cycles / stat_wr_throttle_cycles, output, 16.

Function
REQ-014 SHALL keep a free-credit counter per channel of width clog2(ENTRIES)+1: rd starts at RD_ENTRIES, wr starts at WR_ENTRIES.
REQ-015 SHALL reserve credits when a request is issued (rd: len+1, wr: 1) and SHALL release one credit per rd_deq/wr_deq while not_empty; a reserve and a release in the same cycle SHALL apply the net change.
REQ-016 SHALL drive rd_alm_full from a register that is set when free rd credits < THRESHOLD*4; wr_alm_full SHALL likewise be set when free wr credits < THRESHOLD; both SHALL reflect counter state one cycle late.
REQ-017 SHALL accept requests issued while alm_full is high; a reservation exceeding free credits SHALL set credit_err and clamp the counter at 0.
REQ-018 SHALL enqueue every rx_*_valid beat into its FIFO; the data SHALL appear on *_first, with *_not_empty high, the cycle after enqueue.
REQ-019 SHALL drop an rx beat that arrives when its FIFO is full and set the matching *_overflow flag.
REQ-020 SHALL ignore *_deq while the matching FIFO is empty: no credit release and no state change.
REQ-021 SHALL release credits on deq, never on enqueue, so that credits always bound undelivered responses.
REQ-022 SHALL handle the rd and wr channels fully independently.

Reset
REQ-023 While reset_n is low: counters SHALL load their full values, FIFOs SHALL empty, both alm_full outputs SHALL be 1, and error flags and stats SHALL be 0.
REQ-024 Both alm_full outputs SHALL go to 0 on the first cycle after reset_n rises.
REQ-025 Reset asserted mid-operation SHALL discard all queued responses and outstanding reservations.

Configuration
REQ-026 With CCI_MPF_RX_BUF_STATS_EN defined, the stat_* outputs SHALL count cycles in which the matching alm_full is high; the counts SHALL saturate at 16'hFFFF.
REQ-027 Without CCI_MPF_RX_BUF_STATS_EN, the stat_* ports SHALL remain present and be tied to 0, and no counter logic SHALL be built.

Structure
REQ-028 Package cci_mpf_rx_buf_pkg SHALL hold the t_rx_credits typedef, the beat-per-line constant (4) and the slack-computation functions.
REQ-029 The credit counter SHALL be sub-module cci_mpf_shim_rx_credit_ctr, instantiated once per channel.
REQ-030 Storage SHALL use two cci_mpf_prim_fifo_lutram instances.

Verification
REQ-031 Reset, then 8 reads of len=3 over 8 cycles -> free rd = 32; rd_alm_full still 0; at 9 reads (free 28) rd_alm_full = 1 one cycle later.
REQ-032 Deliver 4 rx_rd beats, then deq 4 -> rd_first matches the input order; free credits rise by 4; rd_alm_full drops once free >= 32.
REQ-033 Same-cycle tx_rd_req len=0 and rd_deq -> credit count unchanged.
REQ-034 65th rx_rd beat with 0 deqs -> beat dropped, rd_overflow = 1 sticky until reset.
REQ-035 Reservation of 4 beats with 2 credits free -> credit_err = 1, counter reads 0.
REQ-036 Macro on, wr_alm_full held for 100 cycles -> stat_wr_throttle_cycles = 100; macro off -> 0.
